// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall bit positions,
// stop values and controller FSM states.
package pipe_ctrl_pkg;

    localparam int STALL_W   = 6;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_e;

    // Stop every stage from the PC up to and including stage `top`.
    function automatic logic [STALL_W-1:0] stall_upto(input int top);
        logic [STALL_W-1:0] v;
        for (int k = 0; k < STALL_W; k++) begin
            v[k] = (k <= top) ? STOP : NO_STOP;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// Priority encoder from per-stage stall requests to the 6-bit stall vector;
// the most downstream requester decides how far back the pipeline freezes.
module stall_encoder
    import pipe_ctrl_pkg::*;
(
    input  logic               i_req_if,
    input  logic               i_req_id,
    input  logic               i_req_ex,
    input  logic               i_req_mem,
    output logic [STALL_W-1:0] o_stall
);

    always_comb begin
        o_stall = '0;
        if (i_req_mem) begin
            o_stall = stall_upto(STALL_MEM);
        end else if (i_req_ex) begin
            o_stall = stall_upto(STALL_EX);
        end else if (i_req_id) begin
            o_stall = stall_upto(STALL_ID);
        end else if (i_req_if) begin
            o_stall = stall_upto(STALL_IF);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall merge, trap/mret flush sequencing and
// branch redirects. Optional stall watchdog enabled by STALL_WATCHDOG_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               n_rst_i,
    input  logic               stall_req_if_i,
    input  logic               stall_req_id_i,
    input  logic               stall_req_ex_i,
    input  logic               stall_req_mem_i,
    input  logic               branch_req_i,
    input  logic [31:0]        branch_pc_i,
    input  logic               trap_req_i,
    input  logic               mret_req_i,
    input  logic [31:0]        mtvec_i,
    input  logic [31:0]        mepc_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic               flush_front_o,
    output logic               redirect_o,
    output logic [31:0]        redirect_pc_o,
    output logic               trap_taken_o,
    output logic               stall_timeout_o
);

    ctrl_state_e        r_state;
    logic [31:0]        r_target;
    logic               r_is_trap;
    logic               r_flush;
    logic               r_trap_taken;
    logic [31:0]        r_redirect_pc;

    logic [STALL_W-1:0] w_stall_vec;
    logic               w_accept;
    logic [31:0]        w_new_target;
    logic               w_branch_take;

    stall_encoder u_stall_encoder (
        .i_req_if  (stall_req_if_i),
        .i_req_id  (stall_req_id_i),
        .i_req_ex  (stall_req_ex_i),
        .i_req_mem (stall_req_mem_i),
        .o_stall   (w_stall_vec)
    );

    // Trap beats mret when both arrive together.
    assign w_accept      = (r_state == ST_RUN) && (trap_req_i || mret_req_i);
    assign w_new_target  = trap_req_i ? mtvec_i : mepc_i;
    assign w_branch_take = (r_state == ST_RUN) && branch_req_i && !trap_req_i && !mret_req_i
                           && !stall_req_ex_i && !stall_req_mem_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_state       <= ST_RUN;
            r_target      <= '0;
            r_is_trap     <= 1'b0;
            r_flush       <= 1'b0;
            r_trap_taken  <= 1'b0;
            r_redirect_pc <= RESET_PC;
        end else begin
            r_flush       <= 1'b0;
            r_trap_taken  <= 1'b0;
            r_redirect_pc <= '0;
            unique case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        r_target  <= w_new_target;
                        r_is_trap <= trap_req_i;
                        if (stall_req_mem_i) begin
                            r_state <= ST_PEND;
                        end else begin
                            r_state       <= ST_FLUSH;
                            r_flush       <= 1'b1;
                            r_trap_taken  <= trap_req_i;
                            r_redirect_pc <= w_new_target;
                        end
                    end
                end
                ST_PEND: begin
                    // Wait for the LSU bus to drain before killing the pipeline.
                    if (!stall_req_mem_i) begin
                        r_state       <= ST_FLUSH;
                        r_flush       <= 1'b1;
                        r_trap_taken  <= r_is_trap;
                        r_redirect_pc <= r_target;
                    end
                end
                ST_FLUSH: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    assign stall_o       = (r_state == ST_FLUSH) ? '0 : w_stall_vec;
    assign flush_o       = r_flush;
    assign trap_taken_o  = r_trap_taken;
    assign flush_front_o = w_branch_take;
    assign redirect_o    = r_flush | w_branch_take;
    assign redirect_pc_o = w_branch_take ? branch_pc_i : r_redirect_pc;

`ifdef STALL_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    logic [15:0] r_wdog_cnt;
    logic        r_timeout;
    logic [15:0] w_wdog_next;

    // Saturate at the limit so a long stall produces a single pulse.
    assign w_wdog_next = !(|stall_o)              ? 16'd0 :
                         (r_wdog_cnt == WDOG_LAST) ? WDOG_LAST : r_wdog_cnt + 16'd1;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_wdog_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_next;
            r_timeout  <= (w_wdog_next == WDOG_LAST) && (r_wdog_cnt != WDOG_LAST);
        end
    end

    assign stall_timeout_o = r_timeout;
`else
    logic w_unused_wdog;
    assign w_unused_wdog   = |WDOG_CYCLES;
    assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed and random stimulus scored
// against a cycle-level reference model of the controller's rules.
module tb_pipe_ctrl;

    localparam logic [31:0] RST_PC = 32'hDEAD_0000;
    localparam int          WDOG   = 8;
`ifdef STALL_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        n_rst_i = 1'b0;
    logic        stall_req_if_i = 0, stall_req_id_i = 0, stall_req_ex_i = 0, stall_req_mem_i = 0;
    logic        branch_req_i = 0, trap_req_i = 0, mret_req_i = 0;
    logic [31:0] branch_pc_i = 0, mtvec_i = 0, mepc_i = 0;
    logic [5:0]  stall_o;
    logic        flush_o, flush_front_o, redirect_o, trap_taken_o, stall_timeout_o;
    logic [31:0] redirect_pc_o;

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(.RESET_PC(RST_PC), .WDOG_CYCLES(WDOG)) dut (
        .clk_i(clk_i), .n_rst_i(n_rst_i),
        .stall_req_if_i(stall_req_if_i), .stall_req_id_i(stall_req_id_i),
        .stall_req_ex_i(stall_req_ex_i), .stall_req_mem_i(stall_req_mem_i),
        .branch_req_i(branch_req_i), .branch_pc_i(branch_pc_i),
        .trap_req_i(trap_req_i), .mret_req_i(mret_req_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .stall_o(stall_o), .flush_o(flush_o), .flush_front_o(flush_front_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .trap_taken_o(trap_taken_o), .stall_timeout_o(stall_timeout_o)
    );

    typedef struct {
        logic        if_r, id_r, ex_r, mem_r, br, trap, mret;
        logic [31:0] bpc, mtvec, mepc;
    } stim_t;

    typedef struct {
        logic [5:0]  stall;
        logic        flush, flush_front, redirect, trap_taken, timeout;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: a trap/mret waiting for the bus, the one-cycle
    // flush slot, the captured target and the current stall run length.
    bit          m_in_reset = 1'b1;
    bit          m_waiting = 1'b0, m_flush_now = 1'b0, m_is_trap = 1'b0;
    logic [31:0] m_target = '0;
    int          m_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic stim_t zero_stim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // The deepest stalled stage freezes itself and everything upstream.
    function automatic logic [5:0] ref_stall(input stim_t s);
        int h = -1;
        if (s.if_r)  h = 1;
        if (s.id_r)  h = 2;
        if (s.ex_r)  h = 3;
        if (s.mem_r) h = 4;
        if (h < 0) return 6'd0;
        return 6'((1 << (h + 1)) - 1);
    endfunction

    task automatic model_cycle(input stim_t s);
        exp_t e;
        bit   br;
        if (m_in_reset) begin
            e = '{stall: 6'd0, flush: 1'b0, flush_front: 1'b0, redirect: 1'b0,
                  trap_taken: 1'b0, timeout: 1'b0, pc: RST_PC};
            sb_q.push_back(e);
            return;
        end
        br = !m_waiting && !m_flush_now && s.br && !s.trap && !s.mret && !s.ex_r && !s.mem_r;
        e.stall       = m_flush_now ? 6'd0 : ref_stall(s);
        e.flush       = m_flush_now;
        e.flush_front = br;
        e.redirect    = m_flush_now || br;
        e.pc          = m_flush_now ? m_target : (br ? s.bpc : 32'd0);
        e.trap_taken  = m_flush_now && m_is_trap;
        e.timeout     = WDOG_ON && (m_run == WDOG - 1);
        sb_q.push_back(e);

        m_run = (e.stall != 6'd0) ? m_run + 1 : 0;
        if (m_flush_now) begin
            m_flush_now = 1'b0;
        end else if (m_waiting) begin
            if (!s.mem_r) begin
                m_waiting   = 1'b0;
                m_flush_now = 1'b1;
            end
        end else if (s.trap || s.mret) begin
            m_target  = s.trap ? s.mtvec : s.mepc;
            m_is_trap = s.trap;
            if (s.mem_r) m_waiting = 1'b1;
            else         m_flush_now = 1'b1;
        end
    endtask

    task automatic apply(input stim_t s);
        stall_req_if_i  = s.if_r;  stall_req_id_i = s.id_r;
        stall_req_ex_i  = s.ex_r;  stall_req_mem_i = s.mem_r;
        branch_req_i    = s.br;    branch_pc_i = s.bpc;
        trap_req_i      = s.trap;  mret_req_i = s.mret;
        mtvec_i         = s.mtvec; mepc_i = s.mepc;
    endtask

    task automatic drive(input stim_t s);
        @(posedge clk_i);
        #1;
        apply(s);
        model_cycle(s);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(zero_stim());
    endtask

    // Reset is asserted mid-cycle and released just before a clock edge.
    task automatic do_reset(input int n);
        @(posedge clk_i);
        #1;
        n_rst_i = 1'b0;
        apply(zero_stim());
        m_in_reset = 1'b1;
        m_waiting = 1'b0; m_flush_now = 1'b0; m_is_trap = 1'b0;
        m_target = '0; m_run = 0;
        model_cycle(zero_stim());
        repeat (n) drive(zero_stim());
        @(negedge clk_i);
        #2;
        n_rst_i = 1'b1;
        m_in_reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("stall_o",         32'(stall_o),         32'(e.stall));
                check("flush_o",         32'(flush_o),         32'(e.flush));
                check("flush_front_o",   32'(flush_front_o),   32'(e.flush_front));
                check("redirect_o",      32'(redirect_o),      32'(e.redirect));
                check("redirect_pc_o",   redirect_pc_o,        e.pc);
                check("trap_taken_o",    32'(trap_taken_o),    32'(e.trap_taken));
                check("stall_timeout_o", 32'(stall_timeout_o), 32'(e.timeout));
            end
        end
    end

    initial begin : watchdog_guard
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by %0t", $time);
        $fatal(1, "bench did not terminate");
    end

    initial begin : stimulus
        stim_t s;
        m_in_reset = 1'b1;
        repeat (2) drive(zero_stim());
        @(negedge clk_i);
        #2;
        n_rst_i = 1'b1;
        m_in_reset = 1'b0;

        s = zero_stim(); s.ex_r = 1'b1;
        repeat (3) drive(s);
        idle(2);

        s = zero_stim(); s.id_r = 1'b1; s.mem_r = 1'b1;
        drive(s);
        idle(1);

        s = zero_stim(); s.trap = 1'b1; s.mtvec = 32'h0000_0100;
        drive(s);
        idle(2);

        s = zero_stim(); s.trap = 1'b1; s.mem_r = 1'b1; s.mtvec = 32'h0000_0200;
        drive(s);
        s = zero_stim(); s.mem_r = 1'b1;
        repeat (4) drive(s);
        idle(3);

        s = zero_stim(); s.mret = 1'b1; s.mepc = 32'h8000_0040;
        drive(s);
        s = zero_stim(); s.br = 1'b1; s.bpc = 32'h0000_1234;
        drive(s);
        drive(s);
        idle(1);

        s = zero_stim(); s.trap = 1'b1; s.mret = 1'b1; s.br = 1'b1;
        s.mtvec = 32'h0000_0300; s.mepc = 32'h0000_0400; s.bpc = 32'h0000_0500;
        drive(s);
        idle(2);

        s = zero_stim(); s.br = 1'b1; s.ex_r = 1'b1; s.bpc = 32'h0000_0600;
        drive(s);
        s.ex_r = 1'b0; s.mem_r = 1'b1;
        drive(s);
        idle(1);

        s = zero_stim(); s.if_r = 1'b1;
        repeat (20) drive(s);
        idle(2);
        s = zero_stim(); s.ex_r = 1'b1;
        repeat (5) drive(s);
        do_reset(2);
        repeat (10) drive(s);
        idle(2);

        s = zero_stim(); s.trap = 1'b1; s.mem_r = 1'b1; s.mtvec = 32'h0000_0700;
        drive(s);
        s = zero_stim(); s.mem_r = 1'b1;
        repeat (2) drive(s);
        do_reset(1);
        idle(3);

        s = zero_stim(); s.mret = 1'b1; s.mepc = 32'h0000_0800;
        drive(s);
        do_reset(1);
        idle(3);

        for (int i = 0; i < 500; i++) begin
            s.if_r  = ($urandom_range(0, 3) == 0);
            s.id_r  = ($urandom_range(0, 4) == 0);
            s.ex_r  = ($urandom_range(0, 4) == 0);
            s.mem_r = ($urandom_range(0, 3) == 0);
            s.br    = ($urandom_range(0, 3) == 0);
            s.trap  = ($urandom_range(0, 15) == 0);
            s.mret  = ($urandom_range(0, 15) == 0);
            s.bpc   = $urandom;
            s.mtvec = $urandom;
            s.mepc  = $urandom;
            drive(s);
        end
        idle(3);

        @(negedge clk_i);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
